trim_rx: RTL and testbench

Serial trim-code receiver on the CLK50 domain, directly downstream of the trim-code generator. Oversamples the generator's ENCLK/DOUT pair, deserializes WIDTH-bit LSB-first frames and presents each completed word on a parallel bus with a one-cycle valid strobe, for the BGR trim DAC and for readback. Partial frames are discarded by an inactivity timeout, keeping the receiver aligned after glitches or a mid-frame generator reset.

---
 rtl/trim_rx.sv | 212 +++++++++++++++++++++
 tb/tb_trim_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/trim_rx.sv
// trim_rx: serial trim-code receiver on the CLK50 domain.
//
// Oversamples the trim-code generator's ENCLK/DOUT pair, deserializes
// WIDTH-bit LSB-first frames and presents each completed word on TRIM_Q
// with a one-cycle TRIM_VALID strobe. Optional inactivity timeout aborts
// partial frames so the receiver realigns after glitches.
//
// Optional feature macro: TRIM_RX_GAP_CHECK_EN
//   defined     -> gap counter present; a partial frame idle for GAP_CYCLES
//                  is dropped with a FRAME_ERR pulse.
//   not defined -> no gap counter, FRAME_ERR stays 0, partial frames persist.
//
// Parameters:
//   WIDTH       bits per frame
//   SYNC_STAGES synchronizer depth for ENCLK and DIN (>= 2)
//   GAP_CYCLES  CLK50 cycles without an ENCLK rise that abort a partial frame
//
// Ports:
//   CLK50      in   system clock
//   RST        in   asynchronous active-high reset
//   ENCLK      in   serial bit clock (asynchronous)
//   DIN        in   serial data (asynchronous)
//   TRIM_Q     out  last complete received word
//   TRIM_VALID out  one-cycle pulse when TRIM_Q updates
//   FRAME_ERR  out  one-cycle pulse when a partial frame is aborted
//   BUSY       out  high while a frame is partially received
//   FRAME_CNT  out  completed-frame count, wraps 255 -> 0
module trim_rx #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             ENCLK,
  input  logic             DIN,
  output logic [WIDTH-1:0] TRIM_Q,
  output logic             TRIM_VALID,
  output logic             FRAME_ERR,
  output logic             BUSY,
  output logic [7:0]       FRAME_CNT
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] enclk_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   enclk_d;
  logic                   enclk_s;
  logic                   din_s;
  logic                   enclk_rise;

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      enclk_sync <= '0;
      din_sync   <= '0;
      enclk_d    <= 1'b0;
    end else begin
      enclk_sync <= {enclk_sync[SYNC_STAGES-2:0], ENCLK};
      din_sync   <= {din_sync[SYNC_STAGES-2:0], DIN};
      enclk_d    <= enclk_sync[SYNC_STAGES-1];
    end
  end

  assign enclk_s    = enclk_sync[SYNC_STAGES-1];
  assign din_s      = din_sync[SYNC_STAGES-1];
  assign enclk_rise = enclk_s & ~enclk_d;

  // ---------------------------------------------------------------------
  // Inactivity timeout
  // ---------------------------------------------------------------------
  logic timeout;

`ifdef TRIM_RX_GAP_CHECK_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [GW-1:0] gap_cnt;

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      gap_cnt <= '0;
    end else if (enclk_rise) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GW'(GAP_CYCLES)) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  assign timeout = (gap_cnt == GW'(GAP_CYCLES));
`else
  // Never true: the gap check is compiled out in this build.
  assign timeout = (GAP_CYCLES < 0);
`endif

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_n;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] shift_word;
  logic             load;
  logic             abort;

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
    end
  end

  always_comb begin
    // First bit of a frame lands in a cleared register; later bits shift
    // right so that after WIDTH bits the first one sits at bit 0 (LSB-first).
    first_word             = '0;
    first_word[WIDTH-1]    = din_s;
    shift_word             = shreg >> 1;
    shift_word[WIDTH-1]    = din_s;

    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    load      = 1'b0;
    abort     = 1'b0;

    unique case (state)
      S_IDLE: begin
        bit_cnt_n = '0;
        if (enclk_rise) begin
          shreg_n   = first_word;
          bit_cnt_n = CW'(1);
          state_n   = (WIDTH == 1) ? S_DONE : S_RECV;
        end
      end

      S_RECV: begin
        // An edge coinciding with the timeout wins: the bit is kept.
        if (enclk_rise) begin
          shreg_n   = shift_word;
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == CW'(WIDTH - 1)) begin
            state_n = S_DONE;
          end
        end else if (timeout) begin
          abort     = 1'b1;
          shreg_n   = '0;
          bit_cnt_n = '0;
          state_n   = S_IDLE;
        end
      end

      S_DONE: begin
        load = 1'b1;
        // An edge here already belongs to the next frame.
        if (enclk_rise) begin
          shreg_n   = first_word;
          bit_cnt_n = CW'(1);
          state_n   = (WIDTH == 1) ? S_DONE : S_RECV;
        end else begin
          bit_cnt_n = '0;
          state_n   = S_IDLE;
        end
      end

      default: begin
        shreg_n   = '0;
        bit_cnt_n = '0;
        state_n   = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      TRIM_Q     <= '0;
      TRIM_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_CNT  <= '0;
    end else begin
      TRIM_VALID <= load;
      FRAME_ERR  <= abort;
      BUSY       <= (state_n == S_RECV);
      if (load) begin
        TRIM_Q    <= shreg;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_trim_rx.sv
module tb_trim_rx;

  localparam int W   = 12;
  localparam int SS  = 2;
  localparam int GAP = 1000;

  logic         CLK50 = 1'b0;
  logic         RST   = 1'b1;
  logic         ENCLK = 1'b0;
  logic         DIN   = 1'b0;
  logic [W-1:0] TRIM_Q;
  logic         TRIM_VALID;
  logic         FRAME_ERR;
  logic         BUSY;
  logic [7:0]   FRAME_CNT;

  trim_rx #(
    .WIDTH      (W),
    .SYNC_STAGES(SS),
    .GAP_CYCLES (GAP)
  ) dut (
    .CLK50     (CLK50),
    .RST       (RST),
    .ENCLK     (ENCLK),
    .DIN       (DIN),
    .TRIM_Q    (TRIM_Q),
    .TRIM_VALID(TRIM_VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY),
    .FRAME_CNT (FRAME_CNT)
  );

  always #5 CLK50 = ~CLK50;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rise = 0;
  int n_valid = 0;
  int obs_err = 0;
  int err_pend = 0;

  // Transaction-level model: bits sent so far in the current frame, words
  // that must still appear on TRIM_Q, and the word/count currently visible.
  bit           model_bits[$];
  logic [W-1:0] exp_fifo[$];
  logic [W-1:0] exp_q = '0;
  logic [7:0]   exp_cnt = '0;

  always @(posedge CLK50) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge CLK50) begin
    if (!RST) begin
      if (TRIM_VALID) begin
        n_valid++;
        chk("valid_expected", int'(exp_fifo.size() > 0), 1);
        if (exp_fifo.size() > 0) begin
          exp_q   = exp_fifo.pop_front();
          exp_cnt = exp_cnt + 8'd1;
        end
        chk("valid_latency", cyc - last_rise, SS + 2);
      end
      chk("trim_q", int'(TRIM_Q), int'(exp_q));
      chk("frame_cnt", int'(FRAME_CNT), int'(exp_cnt));
      chk("valid_err_exclusive", int'(TRIM_VALID & FRAME_ERR), 0);
      if (FRAME_ERR) begin
        obs_err++;
        chk("err_expected", int'(err_pend > 0), 1);
        if (err_pend > 0) err_pend--;
        chk("err_timing", int'((cyc - last_rise >= GAP + 2) && (cyc - last_rise <= GAP + 5)), 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK50);
      #1;
    end
  endtask

  task automatic send_bit(input bit b, input int half);
    logic [W-1:0] word;
    DIN = b;
    tick(1);
    ENCLK = 1'b1;
    last_rise = cyc;
    model_bits.push_back(b);
    if (model_bits.size() == W) begin
      for (int i = 0; i < W; i++) word[i] = model_bits[i];
      exp_fifo.push_back(word);
      model_bits.delete();
    end
    tick(half);
    ENCLK = 1'b0;
    tick(half - 1);
  endtask

  task automatic send_word(input logic [W-1:0] word, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) send_bit(word[i], half);
  endtask

  task automatic idle(input int n);
`ifdef TRIM_RX_GAP_CHECK_EN
    if (n > GAP + 6 && model_bits.size() > 0) begin
      model_bits.delete();
      err_pend++;
    end
`endif
    tick(n);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    model_bits.delete();
    exp_fifo.delete();
    exp_q   = '0;
    exp_cnt = '0;
    err_pend = 0;
    tick(n);
    chk("rst_trim_q", int'(TRIM_Q), 0);
    chk("rst_valid", int'(TRIM_VALID), 0);
    chk("rst_err", int'(FRAME_ERR), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_cnt", int'(FRAME_CNT), 0);
    RST = 1'b0;
    tick(2);
  endtask

  initial begin
    tick(1);
    do_reset(3);

    // Single frame, ENCLK period 20 cycles.
    n_valid = 0;
    send_word(12'hA5C, W, 10);
    tick(6);
    chk("t1_q", int'(TRIM_Q), 'hA5C);
    chk("t1_cnt", int'(FRAME_CNT), 1);
    chk("t1_busy", int'(BUSY), 0);
    chk("t1_nvalid", n_valid, 1);

    // Three back-to-back frames.
    do_reset(3);
    n_valid = 0;
    send_word(12'h001, W, 4);
    send_word(12'h002, W, 4);
    send_word(12'h003, W, 4);
    tick(6);
    chk("t2_q", int'(TRIM_Q), 'h003);
    chk("t2_cnt", int'(FRAME_CNT), 3);
    chk("t2_nvalid", n_valid, 3);

    // Partial frame followed by a long gap.
    obs_err = 0;
    send_word(12'h2B5, 7, 4);
    chk("t3_busy_mid", int'(BUSY), 1);
    idle(1200);
`ifdef TRIM_RX_GAP_CHECK_EN
    chk("t3_err_count", obs_err, 1);
    chk("t3_q_kept", int'(TRIM_Q), 'h003);
    chk("t3_busy_after", int'(BUSY), 0);
    send_word(12'hFFF, W, 4);
    tick(6);
    chk("t3_q_fff", int'(TRIM_Q), 'hFFF);
    chk("t3_cnt", int'(FRAME_CNT), 4);
`else
    chk("t3_err_count", obs_err, 0);
    chk("t3_busy_held", int'(BUSY), 1);
    send_word(12'h01F, 5, 4);
    tick(6);
    chk("t3_q_mixed", int'(TRIM_Q), 'hFB5);
    send_word(12'hFFF, W, 4);
    tick(6);
    chk("t3_q_fff", int'(TRIM_Q), 'hFFF);
    chk("t3_cnt", int'(FRAME_CNT), 5);
`endif

    // Reset in the middle of a frame.
    send_word(12'h0AB, 6, 4);
    do_reset(3);
    send_word(12'h3C3, W, 4);
    tick(6);
    chk("t4_q", int'(TRIM_Q), 'h3C3);
    chk("t4_cnt", int'(FRAME_CNT), 1);

    // Frame counter wrap.
    do_reset(3);
    n_valid = 0;
    for (int f = 0; f < 256; f++) send_word(12'h0F0, W, 4);
    tick(6);
    chk("t5_cnt_wrap", int'(FRAME_CNT), 0);
    chk("t5_nvalid", n_valid, 256);
    chk("t5_q", int'(TRIM_Q), 'h0F0);
    chk("t5_busy", int'(BUSY), 0);

    chk("end_pending_words", exp_fifo.size(), 0);
    chk("end_pending_errs", err_pend, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
